// File: rtl/round_controller.sv
// Round controller for a guess-the-key game: latches a round's numbers and key,
// times the player's guess, scores hits, and counts down lives until game over.
module round_controller #(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int HOLD_CYCLES    = 25000000,
    parameter int LIVES          = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] RNG_1,
    input  logic [3:0] RNG_2,
    input  logic [3:0] RNG_3,
    input  logic [3:0] Key,
    input  logic       guess_valid,
    input  logic [3:0] guess,
    output logic [3:0] Num_1,
    output logic [3:0] Num_2,
    output logic [3:0] Num_3,
    output logic [7:0] Score,
    output logic [1:0] Lives,
    output logic       Hit,
    output logic       Miss,
    output logic       Timeout,
    output logic       Game_Over,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_RESULT = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam logic [26:0] TIMEOUT_LAST = 27'(TIMEOUT_CYCLES - 1);
    localparam logic [26:0] HOLD_LAST    = 27'(HOLD_CYCLES - 1);
    localparam logic [1:0]  LIVES_INIT   = 2'(LIVES);

    state_t      state_r;
    logic [3:0]  key_r;
    logic [26:0] timer_r;
    logic [26:0] hold_r;

    logic        hit_s;
    logic        timeout_s;
    logic        hold_done_s;
    logic [1:0]  lives_dec_s;
    logic [7:0]  score_inc_s;

    assign State = state_r;

    // Round decisions: guess match, timer expiry, dwell end, saturating score/lives updates.
    always_comb begin
        hit_s       = (guess == key_r);
        timeout_s   = (timer_r == TIMEOUT_LAST);
        hold_done_s = (hold_r == HOLD_LAST);
        if (Lives != 2'd0) begin
            lives_dec_s = Lives - 2'd1;
        end else begin
            lives_dec_s = 2'd0;
        end
        if (Score != 8'hFF) begin
            score_inc_s = Score + 8'd1;
        end else begin
            score_inc_s = Score;
        end
    end

    // Game FSM with all outputs registered; result pulses default low every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            key_r     <= 4'd0;
            timer_r   <= 27'd0;
            hold_r    <= 27'd0;
            Num_1     <= 4'd0;
            Num_2     <= 4'd0;
            Num_3     <= 4'd0;
            Score     <= 8'd0;
            Lives     <= 2'd0;
            Hit       <= 1'b0;
            Miss      <= 1'b0;
            Timeout   <= 1'b0;
            Game_Over <= 1'b0;
        end else begin
            Hit     <= 1'b0;
            Miss    <= 1'b0;
            Timeout <= 1'b0;
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        Num_1     <= RNG_1;
                        Num_2     <= RNG_2;
                        Num_3     <= RNG_3;
                        key_r     <= Key;
                        Score     <= 8'd0;
                        Lives     <= LIVES_INIT;
                        timer_r   <= 27'd0;
                        hold_r    <= 27'd0;
                        Game_Over <= 1'b0;
                        state_r   <= ST_PLAY;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_PLAY: begin
                    // A guess on the expiry cycle wins over the timeout.
                    if (guess_valid) begin
                        if (hit_s) begin
                            Score <= score_inc_s;
                            Hit   <= 1'b1;
                        end else begin
                            Lives <= lives_dec_s;
                            Miss  <= 1'b1;
                        end
                        hold_r  <= 27'd0;
                        state_r <= ST_RESULT;
                    end else if (timeout_s) begin
                        Lives   <= lives_dec_s;
                        Miss    <= 1'b1;
                        Timeout <= 1'b1;
                        hold_r  <= 27'd0;
                        state_r <= ST_RESULT;
                    end else begin
                        timer_r <= timer_r + 27'd1;
                    end
                end
                ST_RESULT: begin
                    if (hold_done_s) begin
                        if (Lives == 2'd0) begin
                            Game_Over <= 1'b1;
                            state_r   <= ST_OVER;
                        end else begin
                            Num_1   <= RNG_1;
                            Num_2   <= RNG_2;
                            Num_3   <= RNG_3;
                            key_r   <= Key;
                            timer_r <= 27'd0;
                            state_r <= ST_PLAY;
                        end
                    end else begin
                        hold_r <= hold_r + 27'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: a behavioural game model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_round_controller;

    localparam int TO = 8;
    localparam int HD = 2;
    localparam int LV = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] RNG_1 = 4'd0, RNG_2 = 4'd0, RNG_3 = 4'd0, Key = 4'd0;
    logic       guess_valid = 1'b0;
    logic [3:0] guess = 4'd0;
    logic [3:0] Num_1, Num_2, Num_3;
    logic [7:0] Score;
    logic [1:0] Lives;
    logic       Hit, Miss, Timeout, Game_Over;
    logic [1:0] State;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    round_controller #(.TIMEOUT_CYCLES(TO), .HOLD_CYCLES(HD), .LIVES(LV)) dut (
        .clk(clk), .rst(rst), .start(start),
        .RNG_1(RNG_1), .RNG_2(RNG_2), .RNG_3(RNG_3), .Key(Key),
        .guess_valid(guess_valid), .guess(guess),
        .Num_1(Num_1), .Num_2(Num_2), .Num_3(Num_3),
        .Score(Score), .Lives(Lives), .Hit(Hit), .Miss(Miss), .Timeout(Timeout),
        .Game_Over(Game_Over), .State(State)
    );

    // Game model: phase 0 idle, 1 play, 2 result, 3 over; m_cnt is cycles spent in the phase.
    int         m_phase, m_cnt, m_score, m_lives;
    logic [3:0] m_n1, m_n2, m_n3, m_key;
    logic       m_hit, m_miss, m_to;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0; m_cnt <= 0; m_score <= 0; m_lives <= 0;
            m_n1 <= 4'd0; m_n2 <= 4'd0; m_n3 <= 4'd0; m_key <= 4'd0;
            m_hit <= 1'b0; m_miss <= 1'b0; m_to <= 1'b0;
        end else begin
            m_hit <= 1'b0; m_miss <= 1'b0; m_to <= 1'b0;
            if ((m_phase == 0 || m_phase == 3) && start) begin
                m_phase <= 1; m_cnt <= 0; m_score <= 0; m_lives <= LV;
                m_n1 <= RNG_1; m_n2 <= RNG_2; m_n3 <= RNG_3; m_key <= Key;
            end else if (m_phase == 1 && guess_valid) begin
                m_phase <= 2; m_cnt <= 0;
                if (guess == m_key) begin
                    m_hit <= 1'b1;
                    m_score <= (m_score < 255) ? m_score + 1 : 255;
                end else begin
                    m_miss <= 1'b1;
                    m_lives <= m_lives - 1;
                end
            end else if (m_phase == 1 && m_cnt == TO - 1) begin
                m_phase <= 2; m_cnt <= 0;
                m_miss <= 1'b1; m_to <= 1'b1; m_lives <= m_lives - 1;
            end else if (m_phase == 2 && m_cnt == HD - 1) begin
                m_cnt <= 0;
                if (m_lives == 0) begin
                    m_phase <= 3;
                end else begin
                    m_phase <= 1;
                    m_n1 <= RNG_1; m_n2 <= RNG_2; m_n3 <= RNG_3; m_key <= Key;
                end
            end else if (m_phase == 1 || m_phase == 2) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check_model();
        logic [27:0] exp_v, act_v;
        exp_v = {2'(m_phase), m_n1, m_n2, m_n3, 8'(m_score), 2'(m_lives),
                 m_hit, m_miss, m_to, (m_phase == 3)};
        act_v = {State, Num_1, Num_2, Num_3, Score, Lives, Hit, Miss, Timeout, Game_Over};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic check_lit(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_guess(input logic [3:0] g);
        int waited;
        waited = 0;
        while (State != 2'd1 && waited < 40) begin
            step(1);
            waited++;
        end
        if (State != 2'd1) begin
            vectors++;
            miscompares++;
            $display("FAIL play_wait actual_state=%0d expected_state=1", State);
        end
        guess = g;
        guess_valid = 1'b1;
        step(1);
        guess_valid = 1'b0;
    endtask

    initial begin
        step(3);
        check_lit("rst_state", State, 0);
        check_lit("rst_lives", Lives, 0);
        check_lit("rst_score", Score, 0);
        check_lit("rst_over", Game_Over, 0);

        // Release with start already high: the first edge must start the game.
        rst = 1'b1; start = 1'b1;
        RNG_1 = 4'h5; RNG_2 = 4'h9; RNG_3 = 4'hC; Key = 4'h3;
        step(1);
        start = 1'b0;
        check_lit("start_state", State, 1);
        check_lit("start_num1", Num_1, 5);
        check_lit("start_num2", Num_2, 9);
        check_lit("start_num3", Num_3, 12);
        check_lit("start_score", Score, 0);
        check_lit("start_lives", Lives, 3);

        // Inputs change mid-round; latched key 3 still decides the hit.
        RNG_1 = 4'h1; RNG_2 = 4'h2; RNG_3 = 4'h4; Key = 4'h6;
        do_guess(4'h3);
        check_lit("hit_pulse", Hit, 1);
        check_lit("hit_score", Score, 1);
        check_lit("hit_lives", Lives, 3);
        check_lit("hit_state", State, 2);
        step(1);
        check_lit("hold2_state", State, 2);
        check_lit("hit_one_cycle", Hit, 0);
        step(1);
        check_lit("replay_state", State, 1);
        check_lit("relatch_num3", Num_3, 4);

        // Latched key is 6 now; guess 4 misses.
        Key = 4'h3;
        do_guess(4'h4);
        check_lit("miss_pulse", Miss, 1);
        check_lit("miss_lives", Lives, 2);
        check_lit("miss_no_to", Timeout, 0);
        step(2);
        step(7);
        check_lit("pre_to_state", State, 1);
        step(1);
        check_lit("to_miss", Miss, 1);
        check_lit("to_timeout", Timeout, 1);
        check_lit("to_lives", Lives, 1);

        // Correct guess on the last timer cycle: hit only.
        step(2);
        Key = 4'h5;
        step(7);
        guess = 4'h3; guess_valid = 1'b1;
        step(1);
        guess_valid = 1'b0;
        check_lit("edge_hit", Hit, 1);
        check_lit("edge_no_to", Timeout, 0);
        check_lit("edge_no_miss", Miss, 0);
        check_lit("edge_score", Score, 2);

        // Last life lost -> OVER after the dwell; guesses ignored there.
        do_guess(4'h9);
        check_lit("last_lives", Lives, 0);
        step(2);
        check_lit("over_state", State, 3);
        check_lit("over_flag", Game_Over, 1);
        guess = 4'h5; guess_valid = 1'b1;
        step(3);
        guess_valid = 1'b0;
        check_lit("over_score_hold", Score, 2);
        check_lit("over_no_hit", Hit, 0);

        start = 1'b1;
        step(1);
        start = 1'b0;
        check_lit("restart_state", State, 1);
        check_lit("restart_score", Score, 0);
        check_lit("restart_lives", Lives, 3);
        check_lit("restart_over", Game_Over, 0);

        for (int i = 0; i < 3; i++) do_guess(4'h0);
        step(2);
        check_lit("three_miss_state", State, 3);
        check_lit("three_miss_lives", Lives, 0);

        // Score saturates at 255.
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 257; i++) do_guess(4'h5);
        check_lit("sat_score", Score, 255);
        check_lit("sat_hit", Hit, 1);
        check_lit("sat_lives", Lives, 3);

        // Asynchronous reset in the middle of RESULT.
        #2 rst = 1'b0;
        #1;
        check_lit("arst_state", State, 0);
        check_lit("arst_score", Score, 0);
        check_lit("arst_hit", Hit, 0);
        check_lit("arst_num1", Num_1, 0);
        step(2);
        rst = 1'b1;
        step(3);
        check_lit("post_rst_idle", State, 0);
        check_lit("post_rst_miss", Miss, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_lit("post_rst_start", State, 1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
